// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared state encoding for the CPU run harness.
package cpu_run_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {IDLE, LOAD, HOLD, RUN, DRD, DOUT, DONE} state_t;
endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: host, program-load, CPU, data-memory and dump signals of the run harness.
interface cpu_run_ctrl_if #(
  parameter int DATA_LEN  = 8,
  parameter int ADDR_LEN  = 8,
  parameter int INST_LEN  = 12,
  parameter int IADDR_LEN = 5,
  parameter int CNT_LEN   = 16
);
  logic                 start;
  logic [CNT_LEN-1:0]   run_cycles;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [INST_LEN-1:0]  ld_data;
  logic                 ld_last;
  logic                 im_we;
  logic [IADDR_LEN-1:0] im_addr;
  logic [INST_LEN-1:0]  im_wdata;
  logic                 cpu_rstn;
  logic                 cpu_halt;
  logic                 mem_rd_en;
  logic [ADDR_LEN-1:0]  mem_rd_addr;
  logic [DATA_LEN-1:0]  mem_rd_data;
  logic                 dump_valid;
  logic                 dump_ready;
  logic [DATA_LEN-1:0]  dump_data;
  logic [ADDR_LEN-1:0]  dump_addr;
  logic                 dump_last;
  logic                 busy;
  logic                 done;
  logic [CNT_LEN-1:0]   cycles;
  modport master (
    input  start, run_cycles, ld_valid, ld_data, ld_last, cpu_halt, mem_rd_data, dump_ready,
    output ld_ready, im_we, im_addr, im_wdata, cpu_rstn, mem_rd_en, mem_rd_addr,
           dump_valid, dump_data, dump_addr, dump_last, busy, done, cycles
  );
  modport slave (
    output start, run_cycles, ld_valid, ld_data, ld_last, cpu_halt, mem_rd_data, dump_ready,
    input  ld_ready, im_we, im_addr, im_wdata, cpu_rstn, mem_rd_en, mem_rd_addr,
           dump_valid, dump_data, dump_addr, dump_last, busy, done, cycles
  );
endinterface

// File: rtl/run_dump_stream.sv
// run_dump_stream: read-then-hold dump port; issues a memory read, presents the word until the sink takes it.
module run_dump_stream #(
  parameter int DATA_LEN = 8,
  parameter int ADDR_LEN = 8,
  parameter int MEM_SIZE = 256
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_clr,
  input  logic                i_rd,
  input  logic                i_out,
  input  logic [DATA_LEN-1:0] i_rd_data,
  input  logic                i_ready,
  output logic                o_rd_en,
  output logic                o_valid,
  output logic [DATA_LEN-1:0] o_data,
  output logic [ADDR_LEN-1:0] o_addr,
  output logic                o_last,
  output logic                o_hs
);
  logic [ADDR_LEN-1:0] r_addr;
  logic [DATA_LEN-1:0] r_data;
  logic                r_fresh;
  // Read data is only guaranteed the cycle after the strobe, so pass it through then and hold a copy after.
  assign o_data  = r_fresh ? i_rd_data : r_data;
  assign o_rd_en = i_rd;
  assign o_valid = i_out;
  assign o_addr  = r_addr;
  assign o_last  = i_out && r_addr == ADDR_LEN'(MEM_SIZE - 1);
  assign o_hs    = i_out && i_ready;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_fresh <= 1'b0;
    end else begin
      r_fresh <= i_rd;
      if (r_fresh) r_data <= i_rd_data;
      if (i_clr) r_addr <= '0;
      else if (o_hs && !o_last) r_addr <= r_addr + 1'b1;
    end
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: load program, hold CPU in reset, run for a cycle budget, dump data memory.
// Define CPU_HALT_EN to let cpu_halt end the run early.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int DATA_LEN   = 8,
  parameter int ADDR_LEN   = 8,
  parameter int MEM_SIZE   = 256,
  parameter int INST_LEN   = 12,
  parameter int INST_CAP   = 20,
  parameter int IADDR_LEN  = 5,
  parameter int RST_CYCLES = 1,
  parameter int CNT_LEN    = 16
) (
  input logic            clk,
  input logic            rstn,
  cpu_run_ctrl_if.master bus
);
  state_t               r_state, w_next;
  logic [IADDR_LEN-1:0] r_ptr;
  logic [CNT_LEN-1:0]   r_budget, r_cycles, r_hold;
  logic                 w_start, w_acc, w_load_end, w_hold_end, w_run_end, w_hs, w_last;
  logic [ADDR_LEN-1:0]  w_addr;
  assign w_start    = bus.start && (r_state == IDLE || r_state == DONE);
  assign w_acc      = r_state == LOAD && bus.ld_valid;
  assign w_load_end = w_acc && (bus.ld_last || r_ptr == IADDR_LEN'(INST_CAP - 1));
  assign w_hold_end = r_hold == CNT_LEN'(RST_CYCLES - 1);
`ifdef CPU_HALT_EN
  assign w_run_end  = r_cycles == r_budget - 1'b1 || bus.cpu_halt;
`else
  assign w_run_end  = r_cycles == r_budget - 1'b1;
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: w_next = w_start ? LOAD : r_state;
      LOAD:       w_next = w_load_end ? HOLD : LOAD;
      HOLD:       w_next = w_hold_end ? RUN : HOLD;
      RUN:        w_next = w_run_end ? DRD : RUN;
      DRD:        w_next = DOUT;
      DOUT:       w_next = w_hs ? (w_last ? DONE : DRD) : DOUT;
      default:    w_next = IDLE;
    endcase
  end
  // r_budget stores max(run_cycles,1), so a zero budget still yields one RUN cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_budget <= '0;
      r_cycles <= '0;
      r_hold   <= '0;
    end else begin
      r_state <= w_next;
      r_hold  <= r_state == HOLD ? r_hold + 1'b1 : '0;
      if (w_start) begin
        r_ptr    <= '0;
        r_cycles <= '0;
        r_budget <= bus.run_cycles == '0 ? CNT_LEN'(1) : bus.run_cycles;
      end else begin
        if (w_acc) r_ptr <= r_ptr + 1'b1;
        if (r_state == RUN && !(&r_cycles)) r_cycles <= r_cycles + 1'b1;
      end
    end
  end
  assign bus.ld_ready    = r_state == LOAD;
  assign bus.im_we       = w_acc;
  assign bus.im_addr     = r_ptr;
  assign bus.im_wdata    = w_acc ? bus.ld_data : {INST_LEN{1'b0}};
  assign bus.cpu_rstn    = r_state == RUN;
  assign bus.busy        = r_state != IDLE && r_state != DONE;
  assign bus.done        = r_state == DONE;
  assign bus.cycles      = r_cycles;
  assign bus.mem_rd_addr = w_addr;
  assign bus.dump_addr   = w_addr;
  assign bus.dump_last   = w_last;
  run_dump_stream #(.DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN), .MEM_SIZE(MEM_SIZE)) u_dump (
    .clk       (clk),
    .rstn      (rstn),
    .i_clr     (w_start),
    .i_rd      (r_state == DRD),
    .i_out     (r_state == DOUT),
    .i_rd_data (bus.mem_rd_data),
    .i_ready   (bus.dump_ready),
    .o_rd_en   (bus.mem_rd_en),
    .o_valid   (bus.dump_valid),
    .o_data    (bus.dump_data),
    .o_addr    (w_addr),
    .o_last    (w_last),
    .o_hs      (w_hs)
  );
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized runs of cpu_run_ctrl checked against a transaction-level model.
module tb_cpu_run_ctrl;
  localparam int DATA_LEN = 8, ADDR_LEN = 8, MEM_SIZE = 256, INST_LEN = 12, INST_CAP = 20;
  localparam int IADDR_LEN = 5, RST_CYCLES = 1, CNT_LEN = 16;
`ifdef CPU_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  cpu_run_ctrl_if #(.DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN), .INST_LEN(INST_LEN),
                    .IADDR_LEN(IADDR_LEN), .CNT_LEN(CNT_LEN)) bus ();
  cpu_run_ctrl #(.DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN), .MEM_SIZE(MEM_SIZE), .INST_LEN(INST_LEN),
                 .INST_CAP(INST_CAP), .IADDR_LEN(IADDR_LEN), .RST_CYCLES(RST_CYCLES),
                 .CNT_LEN(CNT_LEN)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Data memory: one-cycle read latency, output scrambled whenever no read is issued.
  logic [DATA_LEN-1:0] dmem [MEM_SIZE];
  always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? dmem[bus.mem_rd_addr] : DATA_LEN'($urandom);
  int wq_addr[$], wq_data[$], bq_addr[$], bq_data[$], bq_last[$];
  int hold_cnt, run_hi, halt_at, runc;
  bit seen_w, run_seen, stalled, stall_en;
  logic [DATA_LEN-1:0] p_data;
  logic [ADDR_LEN-1:0] p_addr;
  logic p_last;
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (bus.im_we) begin
        wq_addr.push_back(int'(bus.im_addr));
        wq_data.push_back(int'(bus.im_wdata));
        hold_cnt = 0;
        seen_w = 1'b1;
      end else if (seen_w && !run_seen && !bus.cpu_rstn) hold_cnt++;
      if (bus.cpu_rstn) begin
        run_seen = 1'b1;
        run_hi++;
      end
      if (stalled) begin
        check("stall_valid", 32'(bus.dump_valid), 1);
        check("stall_data", 32'(bus.dump_data), 32'(p_data));
        check("stall_addr", 32'(bus.dump_addr), 32'(p_addr));
        check("stall_last", 32'(bus.dump_last), 32'(p_last));
      end
      if (bus.dump_valid && bus.dump_ready) begin
        bq_addr.push_back(int'(bus.dump_addr));
        bq_data.push_back(int'(bus.dump_data));
        bq_last.push_back(int'(bus.dump_last));
      end
      stalled = bus.dump_valid && !bus.dump_ready;
      p_data = bus.dump_data;
      p_addr = bus.dump_addr;
      p_last = bus.dump_last;
    end else stalled = 1'b0;
  end
  initial forever begin
    @(posedge clk);
    #1;
    bus.dump_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (bus.cpu_rstn) runc++;
    bus.cpu_halt = bus.cpu_rstn && runc == halt_at;
  end
  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_dump_valid"}, 32'(bus.dump_valid), 0);
    check({tag, "_cpu_rstn"}, 32'(bus.cpu_rstn), 0);
    check({tag, "_ld_ready"}, 32'(bus.ld_ready), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
  endtask
  // One complete run: load n words (ld_last on word last_idx, -1 = none), then either wait
  // for done and compare everything, or assert rstn when the dump reaches abort_at.
  task automatic do_run(input int n, input int last_idx, input int budget, input int h,
                        input bit stall, input int abort_at);
    logic [INST_LEN-1:0] prog[$];
    int k, idx, exp_run, to;
    for (int i = 0; i < n; i++) prog.push_back(INST_LEN'($urandom));
    wq_addr.delete(); wq_data.delete(); bq_addr.delete(); bq_data.delete(); bq_last.delete();
    hold_cnt = 0; run_hi = 0; seen_w = 0; run_seen = 0; runc = 0;
    halt_at = h; stall_en = stall;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.run_cycles = CNT_LEN'(budget);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.run_cycles = CNT_LEN'($urandom);
    idx = 0;
    for (int c = 0; c < 500; c++) begin
      bus.ld_valid = ($urandom_range(0, 3) != 0) && idx < n;
      bus.ld_data  = idx < n ? prog[idx] : '0;
      bus.ld_last  = idx == last_idx;
      @(negedge clk);
      if (!bus.ld_ready) break;
      if (bus.ld_valid) idx++;
      @(posedge clk); #1;
    end
    check("ld_ready_drop", 32'(bus.ld_ready), 0);
    bus.ld_valid = 1'b1; bus.ld_data = INST_LEN'($urandom); bus.ld_last = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.run_cycles = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (abort_at >= 0) begin
      for (to = 0; to < 20000 && !(bus.dump_valid && int'(bus.dump_addr) == abort_at); to++) @(negedge clk);
      check("abort_reach", 32'(bus.dump_addr), 32'(abort_at));
      rstn = 1'b0;
      @(negedge clk);
      check_idle_outputs("abort");
      bus.ld_valid = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      return;
    end
    for (to = 0; to < 20000 && !bus.done; to++) @(negedge clk);
    check("done", 32'(bus.done), 1);
    check("busy_at_done", 32'(bus.busy), 0);
    bus.ld_valid = 1'b0;
    k = last_idx >= 0 ? last_idx + 1 : n;
    if (k > INST_CAP) k = INST_CAP;
    exp_run = budget == 0 ? 1 : budget;
    if (HALT_EN && h > 0 && h < exp_run) exp_run = h;
    check("n_writes", 32'(wq_addr.size()), 32'(k));
    for (int i = 0; i < k && i < wq_addr.size(); i++) begin
      check("im_addr", 32'(wq_addr[i]), 32'(i));
      check("im_wdata", 32'(wq_data[i]), 32'(prog[i]));
    end
    check("hold_len", 32'(hold_cnt), 32'(RST_CYCLES));
    check("run_len", 32'(run_hi), 32'(exp_run));
    check("cycles", 32'(bus.cycles), 32'(exp_run));
    check("n_beats", 32'(bq_addr.size()), 32'(MEM_SIZE));
    for (int i = 0; i < MEM_SIZE && i < bq_addr.size(); i++) begin
      check("dump_addr", 32'(bq_addr[i]), 32'(i));
      check("dump_data", 32'(bq_data[i]), 32'(dmem[i]));
      check("dump_last", 32'(bq_last[i]), 32'(i == MEM_SIZE - 1));
    end
  endtask
  task automatic fill_random;
    for (int i = 0; i < MEM_SIZE; i++) dmem[i] = DATA_LEN'($urandom);
  endtask
  initial begin
    int n, li;
    bus.start = 1'b0; bus.run_cycles = '0; bus.ld_valid = 1'b0; bus.ld_data = '0;
    bus.ld_last = 1'b0; bus.cpu_halt = 1'b0; bus.dump_ready = 1'b1;
    halt_at = 0; stall_en = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_im_we", 32'(bus.im_we), 0);
    check("reset_mem_rd_en", 32'(bus.mem_rd_en), 0);
    check("reset_dump_last", 32'(bus.dump_last), 0);
    check("reset_dump_addr", 32'(bus.dump_addr), 0);
    check("reset_cycles", 32'(bus.cycles), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < MEM_SIZE; i++) dmem[i] = DATA_LEN'(i) ^ 8'h5A;
    do_run(3, 2, 100, 0, 0, -1);
    fill_random();
    do_run(25, -1, 12, 0, 0, -1);
    do_run(8, 5, 0, 0, 1, -1);
    do_run(5, 4, 100, 37, 0, -1);
    for (int r = 0; r < 4; r++) begin
      fill_random();
      n  = $urandom_range(1, 30);
      li = (n >= INST_CAP && $urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, n - 1);
      do_run(n, li, $urandom_range(0, 200), $urandom_range(0, 1) == 1 ? $urandom_range(1, 220) : 0,
             1'($urandom_range(0, 1)), -1);
    end
    do_run(4, 3, 10, 0, 0, 40);
    fill_random();
    do_run(6, 2, 30, 0, 1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
